// File: rtl/sync_chain.sv
// Multi-flop level synchronizer: the only point where the foreign-domain signal is sampled.
// Pure shift chain so synthesis and timing tools can treat it as one async register group.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2,    // legal range 2..4
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be in 2..4");
  end

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_synchron.sv
// Single-bit CDC synchronizer with optional glitch filter and registered edge detection.
// Edge pulses are formed only from registered levels, so they are glitch-free.
module cdc_synchron #(
  parameter int unsigned SYNC_STAGES = 2,    // legal range 2..4
  parameter logic        RESET_LEVEL = 1'b0, // 1'b1 for idle-high signals
  parameter int unsigned FILTER_LEN  = 0     // legal range 0..255, 0 disables filtering
) (
  input  logic sysClk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic rising_o,
  output logic falling_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("cdc_synchron: SYNC_STAGES must be in 2..4");
  end
  if (FILTER_LEN > 255) begin : g_bad_filter
    $error("cdc_synchron: FILTER_LEN must be in 0..255");
  end

  logic chain_out;
  logic sync_lvl;
  logic prev_q;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_LEVEL(RESET_LEVEL)
  ) u_sync_chain (
    .clk_i (sysClk_i),
    .rst_ni(reset_i),
    .d_i   (async_i),
    .q_o   (chain_out)
  );

  if (FILTER_LEN == 0) begin : g_nofilt
    assign sync_lvl = chain_out;
  end else begin : g_filt
    localparam int unsigned     CntW    = $clog2(FILTER_LEN + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(FILTER_LEN);
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    // Count consecutive edges where the chain disagrees; any agreement restarts the count.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (chain_out != filt_q) begin
        if (cnt_q == CntLast) begin
          filt_d = chain_out;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
    end

    always_ff @(posedge sysClk_i or negedge reset_i) begin
      if (!reset_i) begin
        cnt_q  <= '0;
        filt_q <= RESET_LEVEL;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign sync_lvl = filt_q;
  end

  always_ff @(posedge sysClk_i or negedge reset_i) begin
    if (!reset_i) begin
      prev_q <= RESET_LEVEL;
    end else begin
      prev_q <= sync_lvl;
    end
  end

  assign sync_o    = sync_lvl;
  assign rising_o  = sync_lvl & ~prev_q;
  assign falling_o = prev_q & ~sync_lvl;

endmodule

// File: tb/tb_cdc_synchron.sv
// Bench for cdc_synchron: three instances (defaults, idle-high reset, FILTER_LEN=3)
// checked every cycle against a sample-history reference model plus directed scenarios.
module tb_cdc_synchron;

  localparam int S = 2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] async_v = 3'b010;
  wire  [2:0] sync_v, rise_v, fall_v;

  int   flen [3] = '{0, 0, 3};
  logic rlv  [3] = '{1'b0, 1'b1, 1'b0};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic       hist [$];
  logic [2:0] hist_v [$];
  logic       m_raw  [3];
  logic       m_filt [3];
  logic       m_prev [3];
  int         m_run  [3];
  logic       old_raw;

  // Pulse bookkeeping
  int rise_cnt [3];
  int fall_cnt [3];
  int last_p   [3];
  int alt_err = 0;

  always #5 clk = ~clk;

  cdc_synchron dut_def (
    .sysClk_i (clk),
    .reset_i  (rst_n),
    .async_i  (async_v[0]),
    .sync_o   (sync_v[0]),
    .rising_o (rise_v[0]),
    .falling_o(fall_v[0])
  );

  cdc_synchron #(.RESET_LEVEL(1'b1)) dut_rl (
    .sysClk_i (clk),
    .reset_i  (rst_n),
    .async_i  (async_v[1]),
    .sync_o   (sync_v[1]),
    .rising_o (rise_v[1]),
    .falling_o(fall_v[1])
  );

  cdc_synchron #(.FILTER_LEN(3)) dut_flt (
    .sysClk_i (clk),
    .reset_i  (rst_n),
    .async_i  (async_v[2]),
    .sync_o   (sync_v[2]),
    .rising_o (rise_v[2]),
    .falling_o(fall_v[2])
  );

  // Model: sync level is the input sampled S edges ago; the filter adopts that level
  // once it has disagreed with the output for flen consecutive edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_v.delete();
      for (int i = 0; i < 3; i++) begin
        m_raw[i]  = rlv[i];
        m_filt[i] = rlv[i];
        m_prev[i] = rlv[i];
        m_run[i]  = 0;
      end
    end else begin
      hist_v.push_front(async_v);
      if (hist_v.size() > S) void'(hist_v.pop_back());
      for (int i = 0; i < 3; i++) begin
        m_prev[i] = m_filt[i];
        old_raw   = m_raw[i];
        m_raw[i]  = (hist_v.size() >= S) ? hist_v[S-1][i] : rlv[i];
        if (flen[i] == 0) begin
          m_filt[i] = m_raw[i];
        end else if (old_raw != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] >= flen[i]) begin
            m_filt[i] = old_raw;
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (sync_v[i] !== m_filt[i] || rise_v[i] !== (m_filt[i] & ~m_prev[i]) ||
            fall_v[i] !== (m_prev[i] & ~m_filt[i])) begin
          n_fail++;
          $display("FAIL monitor inst%0d t=%0t: sync/rise/fall got %b%b%b expected %b%b%b", i,
                   $time, sync_v[i], rise_v[i], fall_v[i], m_filt[i],
                   m_filt[i] & ~m_prev[i], m_prev[i] & ~m_filt[i]);
        end
        n_checks++;
        if ((rise_v[i] & fall_v[i]) !== 1'b0) begin
          n_fail++;
          $display("FAIL simultaneous inst%0d t=%0t: rise=%b fall=%b required not both 1", i,
                   $time, rise_v[i], fall_v[i]);
        end
        if (rise_v[i] === 1'b1) begin
          rise_cnt[i]++;
          if (last_p[i] == 1) alt_err++;
          last_p[i] = 1;
        end
        if (fall_v[i] === 1'b1) begin
          fall_cnt[i]++;
          if (last_p[i] == 0) alt_err++;
          last_p[i] = 0;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic clear_counts();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      last_p[i]   = -1;
    end
    alt_err = 0;
    #2;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    async_v = 3'b010;
    step(3);
    n_checks++;
    if (sync_v !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_sync: got %b required 010", sync_v);
    end
    n_checks++;
    if (rise_v !== 3'b000 || fall_v !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: rise=%b fall=%b required 000/000", rise_v, fall_v);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;
    clear_counts();
    step(10);
    n_checks++;
    if (sync_v[1] !== 1'b1 || rise_cnt[1] != 0 || fall_cnt[1] != 0) begin
      n_fail++;
      $display("FAIL idle_high_release: sync=%b rises=%0d falls=%0d required 1/0/0",
               sync_v[1], rise_cnt[1], fall_cnt[1]);
    end
    n_checks++;
    if (rise_cnt[0] != 0 || fall_cnt[0] != 0 || rise_cnt[2] != 0 || fall_cnt[2] != 0) begin
      n_fail++;
      $display("FAIL release_pulses: inst0 %0d/%0d inst2 %0d/%0d required all 0",
               rise_cnt[0], fall_cnt[0], rise_cnt[2], fall_cnt[2]);
    end
  endtask

  task automatic test_rise_fall();
    clear_counts();
    async_v[0] = 1'b1;
    step();
    n_checks++;
    if (sync_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_edge1: sync got %b required 0", sync_v[0]);
    end
    step();
    n_checks++;
    if (sync_v[0] !== 1'b1 || rise_v[0] !== 1'b1 || fall_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_edge2: sync/rise/fall got %b%b%b required 110",
               sync_v[0], rise_v[0], fall_v[0]);
    end
    step();
    n_checks++;
    if (sync_v[0] !== 1'b1 || rise_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_edge3: sync/rise got %b%b required 10", sync_v[0], rise_v[0]);
    end
    step(3);
    async_v[0] = 1'b0;
    step();
    n_checks++;
    if (sync_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_edge1: sync got %b required 1", sync_v[0]);
    end
    step();
    n_checks++;
    if (sync_v[0] !== 1'b0 || fall_v[0] !== 1'b1 || rise_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_edge2: sync/rise/fall got %b%b%b required 001",
               sync_v[0], rise_v[0], fall_v[0]);
    end
    step();
    n_checks++;
    if (fall_v[0] !== 1'b0 || rise_cnt[0] != 1 || fall_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL fall_edge3: fall=%b rises=%0d falls=%0d required 0/1/1",
               fall_v[0], rise_cnt[0], fall_cnt[0]);
    end
  endtask

  task automatic test_filter();
    clear_counts();
    async_v[2] = 1'b1;
    step(2);
    async_v[2] = 1'b0;
    step(10);
    n_checks++;
    if (sync_v[2] !== 1'b0 || rise_cnt[2] != 0 || fall_cnt[2] != 0) begin
      n_fail++;
      $display("FAIL filter_short: sync=%b rises=%0d falls=%0d required 0/0/0",
               sync_v[2], rise_cnt[2], fall_cnt[2]);
    end
    async_v[2] = 1'b1;
    step(4);
    n_checks++;
    if (sync_v[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL filter_early: sync after edge 4 got %b required 0", sync_v[2]);
    end
    step();
    n_checks++;
    if (sync_v[2] !== 1'b1 || rise_v[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL filter_rise: sync/rise after edge 5 got %b%b required 11",
               sync_v[2], rise_v[2]);
    end
    async_v[2] = 1'b0;
    step(10);
    n_checks++;
    if (rise_cnt[2] != 1 || fall_cnt[2] != 1 || sync_v[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL filter_long: rises=%0d falls=%0d sync=%b required 1/1/0",
               rise_cnt[2], fall_cnt[2], sync_v[2]);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    for (int k = 0; k < 8; k++) begin
      async_v[0] = ~async_v[0];
      step(3);
    end
    step(6);
    n_checks++;
    if (rise_cnt[0] != 4 || fall_cnt[0] != 4) begin
      n_fail++;
      $display("FAIL toggle_count: rises=%0d falls=%0d required 4/4", rise_cnt[0], fall_cnt[0]);
    end
    n_checks++;
    if (alt_err != 0) begin
      n_fail++;
      $display("FAIL toggle_alternate: %0d ordering errors required 0", alt_err);
    end
  endtask

  task automatic test_short_pulse();
    clear_counts();
    @(posedge clk);
    #9 async_v[0] = 1'b1;
    #2 async_v[0] = 1'b0;
    step(6);
    n_checks++;
    if (rise_cnt[0] != 1 || fall_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL short_captured: rises=%0d falls=%0d required 1/1", rise_cnt[0], fall_cnt[0]);
    end
    // Pulse entirely between edges is never sampled
    async_v[0] = 1'b1;
    #3 async_v[0] = 1'b0;
    step(6);
    n_checks++;
    if (rise_cnt[0] != 1 || fall_cnt[0] != 1) begin
      n_fail++;
      $display("FAIL short_missed: rises=%0d falls=%0d required 1/1", rise_cnt[0], fall_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    async_v[0] = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sync_v[0] !== 1'b0 || rise_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: sync/rise got %b%b required 00", sync_v[0], rise_v[0]);
    end
    async_v[0] = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(6);
    n_checks++;
    if (rise_cnt[0] != 0 || fall_cnt[0] != 0) begin
      n_fail++;
      $display("FAIL reset_abort_pulse: rises=%0d falls=%0d required 0/0",
               rise_cnt[0], fall_cnt[0]);
    end
    async_v[0] = 1'b1;
    async_v[2] = 1'b1;
    step(8);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sync_v !== 3'b010 || rise_v !== 3'b000 || fall_v !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: sync=%b rise=%b fall=%b required 010/000/000",
               sync_v, rise_v, fall_v);
    end
    async_v = 3'b010;
    step(2);
    rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(3) == 0) async_v[i] = ~async_v[i];
      end
      if (c == 300) rst_n = 1'b0;
      if (c == 302) rst_n = 1'b1;
      step();
    end
    n_checks++;
    if (sync_v !== {m_filt[2], m_filt[1], m_filt[0]}) begin
      n_fail++;
      $display("FAIL random_final: sync=%b required %b", sync_v,
               {m_filt[2], m_filt[1], m_filt[0]});
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      last_p[i]   = -1;
    end
    test_reset();
    test_rise_fall();
    test_filter();
    test_back_to_back();
    test_short_pulse();
    test_reset_mid();
    test_random();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_synchron.md
CDC_SYNCHRON -- requirements
Module: cdc_synchron

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in the synchronizer chain; legal range 2..4.
REQ-002 SHALL have parameter RESET_LEVEL, default 1'b0: value loaded into every state bit on reset (set 1'b1 for idle-high signals such as /SS).
REQ-003 SHALL have parameter FILTER_LEN, default 0: 0 disables glitch filtering; N>0 requires N consecutive equal synchronized samples before sync_o changes.
REQ-004 SHALL have port sysClk_i, input, 1 bit: the single system clock, rising edge active.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port async_i, input, 1 bit: asynchronous level from a foreign clock domain.
REQ-007 SHALL have port sync_o, output, 1 bit: synchronized (and, if enabled, filtered) level of async_i.
REQ-008 SHALL have port rising_o, output, 1 bit: single-cycle pulse on a 0->1 change of sync_o.
REQ-009 SHALL have port falling_o, output, 1 bit: single-cycle pulse on a 1->0 change of sync_o.

Function
REQ-010 SHALL sample async_i only in chain stage 0; no logic between stages; later stages shift on every sysClk_i rising edge.
REQ-011 With FILTER_LEN=0, sync_o SHALL equal the last chain stage: a change of async_i, stable before edge 1, appears on sync_o after edge SYNC_STAGES.
REQ-012 With FILTER_LEN=N>0, sync_o SHALL be a register updated to the last chain stage only after that stage has differed from sync_o for N consecutive edges; any shorter disagreement SHALL reset the count and leave sync_o unchanged.
REQ-013 Added filter latency SHALL be exactly N cycles; counter width SHALL be clog2(N+1) and SHALL saturate, never wrap.
REQ-014 A previous-value register SHALL hold sync_o delayed one cycle.
REQ-015 rising_o SHALL be sync_o AND NOT previous; falling_o SHALL be previous AND NOT sync_o; both are derived only from registers, glitch-free, and high for exactly one cycle per transition.
REQ-016 rising_o and falling_o SHALL never be high in the same cycle.
REQ-017 An input pulse shorter than one sysClk_i period MAY be missed; if captured, it SHALL yield exactly one rising and one falling pulse (FILTER_LEN=0).
REQ-018 Back-to-back input toggles each captured SHALL produce alternating pulses with no pulse lost or merged.

Reset
REQ-019 On reset_i low, all chain stages, sync_o, the previous-value register and the filter counter SHALL immediately take RESET_LEVEL (counter 0), independent of sysClk_i.
REQ-020 rising_o and falling_o SHALL be 0 during reset and SHALL NOT pulse on the first edges after reset release when async_i equals RESET_LEVEL.
REQ-021 Reset asserted mid-transition SHALL abort it; no pulse SHALL be emitted for the aborted change.

Structure
REQ-022 No shared package SHALL be required; parameter defaults and legal ranges SHALL be stated locally with elaboration-time range checks on SYNC_STAGES and FILTER_LEN.
REQ-023 The flip-flop chain SHALL be one natural sub-module, sync_chain (parameters SYNC_STAGES, RESET_LEVEL), marked for synthesis as an asynchronous register chain; the filter and edge detection SHALL reside in cdc_synchron.

Verification
REQ-024 Defaults, reset then async_i 0->1 before edge 1 -> sync_o=1 after edge 2; rising_o=1 for exactly the following cycle; falling_o=0.
REQ-025 Defaults, async_i 1->0 -> sync_o=0 after edge 2; falling_o one-cycle pulse; rising_o=0.
REQ-026 RESET_LEVEL=1, async_i held 1 across reset release -> sync_o=1, no pulses for 10 cycles.
REQ-027 FILTER_LEN=3, async_i high for 2 cycles then low -> sync_o stays 0, no pulses; high for 5 cycles -> sync_o rises 3 cycles after the last chain stage, one rising_o pulse.
REQ-028 Toggle async_i every 3 cycles for 8 toggles -> exactly 4 rising_o and 4 falling_o pulses, alternating, none simultaneous.
REQ-029 Assert reset_i low one cycle after async_i 0->1 -> sync_o=0 immediately, no rising_o during or after reset while async_i returns to 0.
